sprite_rom_arbiter: RTL

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one single-port sprite RAM between a render engine
// (burst reads) and an Avalon-MM host port (single reads/writes).
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   rd_req/rd_base/rd_len: render burst request (held until rd_ack)
//   rd_ack               : one-cycle accept pulse
//   rd_data/rd_valid/rd_last : returned burst words, in order, no gaps
//   h_*                  : Avalon-MM host slave (waitrequest-stalled)
//   rom_*                : sprite RAM port, 1-cycle read latency
module sprite_rom_arbiter #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  // Render side
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [3:0]        rd_len,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  // Host side
  input  logic              h_chipselect,
  input  logic              h_read,
  input  logic              h_write,
  input  logic [ADDR_W-1:0] h_address,
  input  logic [DATA_W-1:0] h_writedata,
  input  logic [1:0]        h_byteenable,
  output logic [DATA_W-1:0] h_readdata,
  output logic              h_waitrequest,
  // Sprite RAM
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_write,
  output logic              rom_debugaccess,
  output logic [DATA_W-1:0] rom_writedata,
  output logic [1:0]        rom_byteenable,
  input  logic [DATA_W-1:0] rom_readdata
);

  typedef enum logic [1:0] {StIdle, StRend, StHostRd, StHostWr} state_e;

  localparam logic [3:0] MaxLen = 4'(MAX_LEN);

  state_e              state_q, state_d;
  logic [3:0]          remain_q, remain_d;     // words still to issue, incl. current
  logic                host_phase_q, host_phase_d;
  logic                last_grant_render_q, last_grant_render_d;
  logic                rd_ack_q, rd_ack_d;
  logic                host_done_q, host_done_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic                rom_cs_q, rom_cs_d;
  logic                rom_wr_q, rom_wr_d;
  logic [DATA_W-1:0]   rom_wdata_q, rom_wdata_d;
  logic [1:0]          rom_be_q, rom_be_d;

  // Return pipeline: ret_* tags the word on rom_readdata this cycle.
  logic                ret_valid_q, ret_last_q;
  logic                rd_valid_q, rd_last_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]  h_readdata_q;

  logic                host_pending;
  logic                host_arb;
  logic                rend_pending;
  logic                can_arb;
  logic                grant_rend;
  logic                grant_host;
  logic [3:0]          eff_len;

  assign host_pending = h_chipselect & (h_read | h_write);
  // The host keeps its request up during the completion cycle; don't re-grant it.
  assign host_arb     = host_pending & ~host_done_q;
  // rd_req is still high while rd_ack is out; that request is already taken.
  assign rend_pending = rd_req & ~rd_ack_q;
  assign eff_len      = (rd_len > MaxLen) ? MaxLen : rd_len;
  // The last REND cycle arbitrates too, so a follow-on request lands at edge L.
  assign can_arb      = (state_q == StIdle) || ((state_q == StRend) && (remain_q == 4'd1));

  always_comb begin
    state_d             = state_q;
    remain_d            = remain_q;
    host_phase_d        = host_phase_q;
    last_grant_render_d = last_grant_render_q;
    rd_ack_d            = 1'b0;
    host_done_d         = 1'b0;
    rom_address_d       = rom_address_q;
    rom_cs_d            = 1'b0;
    rom_wr_d            = 1'b0;
    rom_wdata_d         = rom_wdata_q;
    rom_be_d            = rom_be_q;
    grant_rend          = 1'b0;
    grant_host          = 1'b0;

    unique case (state_q)
      StRend: begin
        if (remain_q != 4'd1) begin
          remain_d      = remain_q - 4'd1;
          rom_address_d = rom_address_q + ADDR_W'(1);
          rom_cs_d      = 1'b1;
        end else begin
          state_d  = StIdle;
          remain_d = 4'd0;
        end
      end
      StHostRd: begin
        if (!host_phase_q) begin
          host_phase_d = 1'b1;
        end else begin
          state_d      = StIdle;
          host_phase_d = 1'b0;
          host_done_d  = 1'b1;
        end
      end
      StHostWr: begin
        state_d     = StIdle;
        host_done_d = 1'b1;
      end
      default: ;
    endcase

    if (can_arb) begin
      // On a tie, grant whichever side did not win last time.
      grant_rend = rend_pending && (!host_arb || !last_grant_render_q);
      grant_host = host_arb && !grant_rend;
      if (grant_rend) begin
        rd_ack_d            = 1'b1;
        last_grant_render_d = 1'b1;
        if (eff_len != 4'd0) begin
          state_d       = StRend;
          remain_d      = eff_len;
          rom_address_d = rd_base;
          rom_cs_d      = 1'b1;
        end
      end else if (grant_host) begin
        last_grant_render_d = 1'b0;
        rom_address_d       = h_address;
        rom_cs_d            = 1'b1;
        if (h_write) begin
          state_d     = StHostWr;
          rom_wr_d    = 1'b1;
          rom_wdata_d = h_writedata;
          rom_be_d    = h_byteenable;
        end else begin
          state_d      = StHostRd;
          host_phase_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= StIdle;
      remain_q            <= 4'd0;
      host_phase_q        <= 1'b0;
      last_grant_render_q <= 1'b0;
      rd_ack_q            <= 1'b0;
      host_done_q         <= 1'b0;
      rom_address_q       <= '0;
      rom_cs_q            <= 1'b0;
      rom_wr_q            <= 1'b0;
      rom_wdata_q         <= '0;
      rom_be_q            <= 2'b00;
      ret_valid_q         <= 1'b0;
      ret_last_q          <= 1'b0;
      rd_valid_q          <= 1'b0;
      rd_last_q           <= 1'b0;
      rd_data_q           <= '0;
      h_readdata_q        <= '0;
    end else begin
      state_q             <= state_d;
      remain_q            <= remain_d;
      host_phase_q        <= host_phase_d;
      last_grant_render_q <= last_grant_render_d;
      rd_ack_q            <= rd_ack_d;
      host_done_q         <= host_done_d;
      rom_address_q       <= rom_address_d;
      rom_cs_q            <= rom_cs_d;
      rom_wr_q            <= rom_wr_d;
      rom_wdata_q         <= rom_wdata_d;
      rom_be_q            <= rom_be_d;
      ret_valid_q         <= (state_q == StRend);
      ret_last_q          <= (state_q == StRend) && (remain_q == 4'd1);
      rd_valid_q          <= ret_valid_q;
      rd_last_q           <= ret_last_q;
      if (ret_valid_q) begin
        rd_data_q <= rom_readdata;
      end
      if ((state_q == StHostRd) && host_phase_q) begin
        h_readdata_q <= rom_readdata;
      end
    end
  end

  assign rd_ack          = rd_ack_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign rd_last         = rd_last_q;
  assign h_readdata      = h_readdata_q;
  assign h_waitrequest   = host_pending & ~host_done_q;
  assign rom_address     = rom_address_q;
  assign rom_chipselect  = rom_cs_q;
  assign rom_write       = rom_wr_q;
  assign rom_debugaccess = rom_wr_q;
  assign rom_writedata   = rom_wdata_q;
  assign rom_byteenable  = rom_be_q;

endmodule
